// File: rtl/data_sram_if.sv
// Request/response bus between an initiator and the data SRAM responder.
// The initiator drives the request side; the responder returns accept and response strobes.
interface data_sram_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        init_done;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata, init_done
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata, init_done
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed SRAM with byte strobes, fixed-latency in-order responses and a
// post-reset sweep that zeroes the whole array before requests are accepted.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_sram_if.slave bus
);
    localparam int DEPTH = 4;
    localparam int WORDS = 2 ** ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [2:0]        cd_q [DEPTH];
    logic [2:0]        cd_d [DEPTH];
    logic [31:0]       pl_q [DEPTH];
    logic [31:0]       pl_d [DEPTH];
    logic [31:0]       mem  [WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic              running;
    logic              accept;
    logic              pop;
    logic              unused_addr_bits;

    assign word_idx         = bus.addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
    assign rd_word          = mem[word_idx];
    assign running          = (state_q == ST_RUN);

    // Acceptance looks only at registered occupancy, so a same-cycle retirement never opens a slot.
    assign bus.addr_ok   = running && (count_q < 3'(DEPTH));
    assign accept        = bus.req && bus.addr_ok;
    assign pop           = (count_q != 3'd0) && (cd_q[rd_ptr_q] == 3'd0);
    assign bus.data_ok   = pop;
    assign bus.rdata     = pop ? pl_q[rd_ptr_q] : 32'h0;
    assign bus.init_done = running;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (cd_q[i] != 3'd0) ? cd_q[i] - 3'd1 : 3'd0;
            pl_d[i] = pl_q[i];
        end

        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end

        if (accept) begin
            cd_d[wr_ptr_q] = 3'(LATENCY - 1);
            pl_d[wr_ptr_q] = bus.wr ? 32'h0 : rd_word;
            wr_ptr_d       = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= '0;
                pl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= cd_d[i];
                pl_q[i] <= pl_d[i];
            end
        end
    end

    // NOTE: the array has no reset term; the INIT sweep zeroes it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (!running) begin
            mem[clr_ptr_q] <= 32'h0;
        end else if (accept && bus.wr && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
